cla_serial_adder: RTL



---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla4.sv | 67 ++++++
 rtl/cla_gates.sv | 44 ++++
 rtl/cla_serial_adder.sv | 110 +++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Shared constants for the nibble-serial carry-lookahead adder:
//             FSM state encodings, slice width and a counter-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SLICE_W = 4;

    // Bits needed to count 0..n-1, never less than one so a single-slice
    // adder still has a real counter register.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla4.sv
`default_nettype none
// ============================================================================
//  Module   : cla4
//  Purpose  : Combinational 4-bit carry-lookahead adder slice built purely
//             from gate-library cells. All carries come from g/p terms and
//             cin directly, so no carry ripples through the slice.
//  Revision : 1.0  initial release
// ============================================================================
module cla4 (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    output logic [3:0] s4,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cy;

    // c1 product terms
    logic t1_0;
    // c2 product terms
    logic t2_0, t2_1;
    // c3 product terms
    logic t3_0, t3_1, t3_2;
    // c4 product terms
    logic t4_0, t4_1, t4_2, t4_3;

    assign cy[0] = cin;

    // Per-bit generate, propagate and sum
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            _and2 u_g (.a(a4[i]), .b(b4[i]),  .y(g[i]));
            _xor2 u_p (.a(a4[i]), .b(b4[i]),  .y(p[i]));
            _xor2 u_s (.a(p[i]),  .b(cy[i]),  .y(s4[i]));
        end
    endgenerate

    // c1 = g0 | p0.c0
    _and2 u_t1_0 (.a(p[0]), .b(cy[0]), .y(t1_0));
    _or2  u_c1   (.a(g[0]), .b(t1_0),  .y(cy[1]));

    // c2 = g1 | p1.g0 | p1.p0.c0
    _and2 u_t2_0 (.a(p[1]), .b(g[0]),                .y(t2_0));
    _and3 u_t2_1 (.a(p[1]), .b(p[0]), .c(cy[0]),     .y(t2_1));
    _or3  u_c2   (.a(g[1]), .b(t2_0), .c(t2_1),      .y(cy[2]));

    // c3 = g2 | p2.g1 | p2.p1.g0 | p2.p1.p0.c0
    _and2 u_t3_0 (.a(p[2]), .b(g[1]),                        .y(t3_0));
    _and3 u_t3_1 (.a(p[2]), .b(p[1]), .c(g[0]),              .y(t3_1));
    _and4 u_t3_2 (.a(p[2]), .b(p[1]), .c(p[0]), .d(cy[0]),   .y(t3_2));
    _or4  u_c3   (.a(g[2]), .b(t3_0), .c(t3_1), .d(t3_2),    .y(cy[3]));

    // c4 = g3 | p3.g2 | p3.p2.g1 | p3.p2.p1.g0 | p3.p2.p1.p0.c0
    _and2 u_t4_0 (.a(p[3]), .b(g[2]),                                  .y(t4_0));
    _and3 u_t4_1 (.a(p[3]), .b(p[2]), .c(g[1]),                        .y(t4_1));
    _and4 u_t4_2 (.a(p[3]), .b(p[2]), .c(p[1]), .d(g[0]),              .y(t4_2));
    _and5 u_t4_3 (.a(p[3]), .b(p[2]), .c(p[1]), .d(p[0]), .e(cy[0]),   .y(t4_3));
    _or5  u_c4   (.a(g[3]), .b(t4_0), .c(t4_1), .d(t4_2), .e(t4_3),    .y(cy[4]));

    assign cout = cy[4];

endmodule
`default_nettype wire

// File: rtl/cla_gates.sv
`default_nettype none
// ============================================================================
//  Module   : _and2 .. _and5, _or2 .. _or5, _xor2
//  Purpose  : Primitive gate library cells used to build the CLA slice.
//  Revision : 1.0  initial release
// ============================================================================
module _and2 (input logic a, input logic b, output logic y);
    assign y = a & b;
endmodule

module _and3 (input logic a, input logic b, input logic c, output logic y);
    assign y = a & b & c;
endmodule

module _and4 (input logic a, input logic b, input logic c, input logic d, output logic y);
    assign y = a & b & c & d;
endmodule

module _and5 (input logic a, input logic b, input logic c, input logic d, input logic e,
              output logic y);
    assign y = a & b & c & d & e;
endmodule

module _or2 (input logic a, input logic b, output logic y);
    assign y = a | b;
endmodule

module _or3 (input logic a, input logic b, input logic c, output logic y);
    assign y = a | b | c;
endmodule

module _or4 (input logic a, input logic b, input logic c, input logic d, output logic y);
    assign y = a | b | c | d;
endmodule

module _or5 (input logic a, input logic b, input logic c, input logic d, input logic e,
             output logic y);
    assign y = a | b | c | d | e;
endmodule

module _xor2 (input logic a, input logic b, output logic y);
    assign y = a ^ b;
endmodule
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_serial_adder
//  Purpose  : WIDTH-bit adder that reuses one 4-bit CLA slice over WIDTH/4
//             cycles, LSB nibble first, with the inter-slice carry held in a
//             flip-flop. valid/ready handshakes on operand and result sides.
//  Revision : 1.0  initial release
// ============================================================================
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = clog2_min1(NSLICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_acc;
    logic [WIDTH-1:0]   s_shift;
    logic               carry;
    logic               co_r;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    // Low nibble of the operand shift registers through the shared slice
    cla4 u_cla4 (
        .a4   (a_sh[SLICE_W-1:0]),
        .b4   (b_sh[SLICE_W-1:0]),
        .cin  (carry),
        .s4   (slice_s),
        .cout (slice_co)
    );

    // New slice sum enters at the top so the LSB nibble ends up at the bottom
    generate
        if (WIDTH > SLICE_W) begin : g_wide
            assign s_shift = {slice_s, s_acc[WIDTH-1:SLICE_W]};
        end else begin : g_single
            assign s_shift = slice_s;
        end
    endgenerate

    // FSM, counter, operand shifters, sum accumulator and carry flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_acc <= '0;
            carry <= 1'b0;
            co_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= ci;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_acc <= s_shift;
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    carry <= slice_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        co_r  <= slice_co;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (o_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);
    assign s       = s_acc;
    assign co      = co_r;

endmodule
`default_nettype wire
